ifft_serial: RTL and testbench

Iterative 8-point radix-2 inverse FFT, the return path for the parallel 8-point forward FFT in the same datapath. It accepts one frame of 8 complex frequency-domain samples serially, computes the IFFT in place with a single time-shared butterfly, and streams out 8 time-domain samples in natural order. The output is scaled by 1/8, so a forward-then-inverse round trip returns the original samples, less truncation error.

---
 rtl/ifft_serial.sv | 176 +++++++++++++++++
 tb/tb_ifft_serial.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_serial.sv
// Iterative 8-point radix-2 inverse FFT: serial load, one shared butterfly,
// natural-order serial unload, output scaled by 1/8.
module ifft_serial #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8,
    parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic                  out_last,
    output logic                  busy
);
    localparam int TW = FRACT_WIDTH + 2;
    localparam int PW = DATA_WIDTH + FRACT_WIDTH + 2;
    localparam int C_INT = int'(real'(1 << FRACT_WIDTH) * 0.7071067811865476);
    localparam logic signed [TW-1:0] ONE = TW'(1 << FRACT_WIDTH);
    localparam logic signed [TW-1:0] CK  = TW'(C_INT);

    typedef enum logic [1:0] {S_LOAD, S_COMP, S_UNLD} state_t;

    state_t                       r_state;
    logic signed [DATA_WIDTH-1:0] r_re [8];
    logic signed [DATA_WIDTH-1:0] r_im [8];
    logic [2:0]                   r_cnt;
    logic [1:0]                   r_stage;
    logic [1:0]                   r_bfly;

    logic [2:0]                   w_wa;
    logic [2:0]                   w_top;
    logic [2:0]                   w_bot;
    logic [1:0]                   w_k;
    logic signed [TW-1:0]         w_wr;
    logic signed [TW-1:0]         w_wi;
    logic signed [DATA_WIDTH-1:0] w_ar;
    logic signed [DATA_WIDTH-1:0] w_ai;
    logic signed [DATA_WIDTH-1:0] w_br;
    logic signed [DATA_WIDTH-1:0] w_bi;
    logic signed [PW-1:0]         w_p_rr;
    logic signed [PW-1:0]         w_p_ii;
    logic signed [PW-1:0]         w_p_ri;
    logic signed [PW-1:0]         w_p_ir;
    logic signed [PW-1:0]         w_sr;
    logic signed [PW-1:0]         w_si;
    logic signed [DATA_WIDTH-1:0] w_tr;
    logic signed [DATA_WIDTH-1:0] w_ti;
    logic [DATA_WIDTH:0]          w_s_re;
    logic [DATA_WIDTH:0]          w_s_im;
    logic [DATA_WIDTH:0]          w_d_re;
    logic [DATA_WIDTH:0]          w_d_im;
    logic                         w_unused;

    assign w_wa = {r_cnt[0], r_cnt[1], r_cnt[2]};

    // Butterfly pair and twiddle index for the current stage/butterfly
    always_comb begin
        w_top = {r_bfly, 1'b0};
        w_bot = {r_bfly, 1'b1};
        w_k   = 2'd0;
        case (r_stage)
            2'd1: begin
                w_top = {r_bfly[1], 1'b0, r_bfly[0]};
                w_bot = {r_bfly[1], 1'b1, r_bfly[0]};
                w_k   = {r_bfly[0], 1'b0};
            end
            2'd2: begin
                w_top = {1'b0, r_bfly};
                w_bot = {1'b1, r_bfly};
                w_k   = r_bfly;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_wr = ONE;
        w_wi = '0;
        case (w_k)
            2'd1: begin w_wr = CK;   w_wi = CK;  end
            2'd2: begin w_wr = '0;   w_wi = ONE; end
            2'd3: begin w_wr = -CK;  w_wi = CK;  end
            default: ;
        endcase
    end

    assign w_ar = r_re[w_top];
    assign w_ai = r_im[w_top];
    assign w_br = r_re[w_bot];
    assign w_bi = r_im[w_bot];

    assign w_p_rr = PW'(w_br) * PW'(w_wr);
    assign w_p_ii = PW'(w_bi) * PW'(w_wi);
    assign w_p_ri = PW'(w_br) * PW'(w_wi);
    assign w_p_ir = PW'(w_bi) * PW'(w_wr);
    assign w_sr   = w_p_rr - w_p_ii;
    assign w_si   = w_p_ri + w_p_ir;
    assign w_tr   = w_sr[FRACT_WIDTH +: DATA_WIDTH];
    assign w_ti   = w_si[FRACT_WIDTH +: DATA_WIDTH];

    // One guard bit so the halved sum/difference cannot overflow
    assign w_s_re = {w_ar[DATA_WIDTH-1], w_ar} + {w_tr[DATA_WIDTH-1], w_tr};
    assign w_s_im = {w_ai[DATA_WIDTH-1], w_ai} + {w_ti[DATA_WIDTH-1], w_ti};
    assign w_d_re = {w_ar[DATA_WIDTH-1], w_ar} - {w_tr[DATA_WIDTH-1], w_tr};
    assign w_d_im = {w_ai[DATA_WIDTH-1], w_ai} - {w_ti[DATA_WIDTH-1], w_ti};

    assign w_unused = ^{w_sr[FRACT_WIDTH-1:0], w_sr[PW-1 -: 2],
                        w_si[FRACT_WIDTH-1:0], w_si[PW-1 -: 2],
                        w_s_re[0], w_s_im[0], w_d_re[0], w_d_im[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_re[w_wa] <= in_real;
                        r_im[w_wa] <= in_imag;
                        r_cnt      <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_COMP;
                            r_stage <= '0;
                            r_bfly  <= '0;
                        end
                    end
                end
                S_COMP: begin
                    r_re[w_top] <= w_s_re[DATA_WIDTH:1];
                    r_im[w_top] <= w_s_im[DATA_WIDTH:1];
                    r_re[w_bot] <= w_d_re[DATA_WIDTH:1];
                    r_im[w_bot] <= w_d_im[DATA_WIDTH:1];
                    r_bfly      <= r_bfly + 2'd1;
                    if (r_bfly == 2'd3) begin
                        r_stage <= r_stage + 2'd1;
                        if (r_stage == 2'd2) begin
                            r_state <= S_UNLD;
                            r_stage <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_UNLD: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_UNLD);
    assign out_last  = (r_state == S_UNLD) && (r_cnt == 3'd7);
    assign busy      = (r_state != S_LOAD);
    assign out_real  = r_re[r_cnt];
    assign out_imag  = r_im[r_cnt];

endmodule

// File: tb/tb_ifft_serial.sv
// Directed testbench for ifft_serial: impulse, DC, tone, backpressure,
// handshake latency, back-to-back frames and reset during compute.
module tb_ifft_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic [15:0] out_real;
    logic [15:0] out_imag;

    int checks = 0;
    int failures = 0;

    logic [15:0] xr [8];
    logic [15:0] xi [8];
    logic [15:0] er [8];
    logic [15:0] ei [8];
    logic [15:0] gr [8];
    logic [15:0] gi [8];

    ifft_serial dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_real (out_real),
        .out_imag (out_imag),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            xr[i] = '0;
            xi[i] = '0;
            er[i] = '0;
            ei[i] = '0;
        end
    endtask

    task automatic load_frame(input bit gappy);
        int k = 0;
        int g = 0;
        bit ph = 1'b1;
        while (k < 8 && g < 64) begin
            @(negedge clk);
            in_valid = gappy ? ph : 1'b1;
            ph = ~ph;
            in_real = xr[k];
            in_imag = xi[k];
            if (in_valid && in_ready) k++;
            g++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (k !== 8) begin
            failures++;
            $display("FAIL load_accepts got=%0d exp=8", k);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_end in_ready=%b busy=%b exp in_ready=0 busy=1",
                     in_ready, busy);
        end
    endtask

    task automatic wait_output();
        int n = 0;
        bit rdy_seen = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (in_ready) rdy_seen = 1'b1;
        end
        checks++;
        if (n !== 12 || rdy_seen) begin
            failures++;
            $display("FAIL latency got=%0d in_ready_seen=%b exp=12 in_ready_seen=0",
                     n, rdy_seen);
        end
    endtask

    task automatic unload(input int stall_at, input string tag);
        int idx = 0;
        int g = 0;
        int st = 0;
        logic [15:0] hr = '0;
        logic [15:0] hi = '0;
        while (idx < 8 && g < 60) begin
            if (out_valid) begin
                if (idx == stall_at && st < 5) begin
                    out_ready = 1'b0;
                    if (st == 0) begin
                        hr = out_real;
                        hi = out_imag;
                    end else begin
                        checks++;
                        if (out_real !== hr || out_imag !== hi || out_last !== 1'b0) begin
                            failures++;
                            $display("FAIL %s hold got=%h,%h last=%b exp=%h,%h last=0",
                                     tag, out_real, out_imag, out_last, hr, hi);
                        end
                    end
                    st++;
                end else begin
                    out_ready = 1'b1;
                    gr[idx] = out_real;
                    gi[idx] = out_imag;
                    checks++;
                    if (out_last !== 1'(idx == 7)) begin
                        failures++;
                        $display("FAIL %s out_last beat=%0d got=%b exp=%b",
                                 tag, idx, out_last, (idx == 7));
                    end
                    idx++;
                end
            end else begin
                out_ready = 1'b0;
            end
            g++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (idx !== 8 || g !== (stall_at >= 0 ? 13 : 8)) begin
            failures++;
            $display("FAIL %s unload_len beats=%0d cycles=%0d exp beats=8 cycles=%0d",
                     tag, idx, g, (stall_at >= 0 ? 13 : 8));
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_unload in_ready=%b out_valid=%b busy=%b exp 1,0,0",
                     tag, in_ready, out_valid, busy);
        end
        if (stall_at >= 0) begin
            checks++;
            if (gr[stall_at] !== hr || gi[stall_at] !== hi) begin
                failures++;
                $display("FAIL %s stalled_value got=%h,%h exp=%h,%h",
                         tag, gr[stall_at], gi[stall_at], hr, hi);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gr[i] !== er[i] || gi[i] !== ei[i]) begin
                failures++;
                $display("FAIL %s out%0d got=%h,%h exp=%h,%h",
                         tag, i, gr[i], gi[i], er[i], ei[i]);
            end
        end
    endtask

    task automatic set_impulse();
        clear_frame();
        xr[0] = 16'h0800;
        for (int i = 0; i < 8; i++) er[i] = 16'h0100;
    endtask

    task automatic set_dc();
        clear_frame();
        for (int i = 0; i < 8; i++) xr[i] = 16'h0100;
        er[0] = 16'h0100;
    endtask

    task automatic set_tone();
        clear_frame();
        xr[1] = 16'h0800;
        er[0] = 16'h0100; ei[0] = 16'h0000;
        er[1] = 16'h00B5; ei[1] = 16'h00B5;
        er[2] = 16'h0000; ei[2] = 16'h0100;
        er[3] = 16'hFF4B; ei[3] = 16'h00B5;
        er[4] = 16'hFF00; ei[4] = 16'h0000;
        er[5] = 16'hFF4B; ei[5] = 16'hFF4B;
        er[6] = 16'h0000; ei[6] = 16'hFF00;
        er[7] = 16'h00B5; ei[7] = 16'hFF4B;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || out_real !== 16'h0 || out_imag !== 16'h0) begin
            failures++;
            $display("FAIL reset rdy=%b ov=%b last=%b busy=%b re=%h im=%h exp 1,0,0,0,0,0",
                     in_ready, out_valid, out_last, busy, out_real, out_imag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        set_impulse();
        load_frame(1'b0);
        wait_output();
        unload(-1, "impulse");
    endtask

    task automatic test_dc();
        set_dc();
        load_frame(1'b0);
        wait_output();
        unload(-1, "dc");
    endtask

    task automatic test_tone_backpressure();
        set_tone();
        load_frame(1'b0);
        wait_output();
        unload(3, "tone_bp");
    endtask

    task automatic test_handshake_gappy();
        set_impulse();
        load_frame(1'b1);
        wait_output();
        unload(-1, "gappy");
    endtask

    task automatic test_back_to_back();
        set_tone();
        load_frame(1'b0);
        wait_output();
        unload(-1, "b2b_tone");
        set_dc();
        load_frame(1'b0);
        wait_output();
        unload(-1, "b2b_dc");
    endtask

    task automatic test_reset_mid_compute();
        set_dc();
        load_frame(1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_real !== 16'h0) begin
            failures++;
            $display("FAIL mid_reset rdy=%b ov=%b busy=%b re=%h exp 1,0,0,0",
                     in_ready, out_valid, busy, out_real);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_impulse();
        load_frame(1'b0);
        wait_output();
        unload(-1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_tone_backpressure();
        test_handshake_gappy();
        test_back_to_back();
        test_reset_mid_compute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
